bcd_display_shifter: RTL and testbench

Reads the four BCD digits of the minutes/seconds time registers and shifts them out serially as 7-segment patterns to an external chain of 74HC595-style shift registers. It is the consumer end of the time-register digit interface. It sits between the minutes_seconds_register pair and the chip's display pins. A frame is triggered by a start pulse, normally the seconds-tick enable.

---
 rtl/bcd_display_shifter.sv | 185 ++++++++++++++++++
 tb/tb_bcd_display_shifter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_shifter.sv
// bcd_display_shifter
// Serialises the four BCD time digits as 7-segment bytes into an external
// 74HC595-style chain: 32 bits MSB first, then a storage-register latch pulse.
// Optional build macro: BLANK_LEADING_ZERO_EN -- blanks a zero tens-of-minutes digit.
module bcd_display_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] msd_minutes,
  input  logic [3:0] lsd_minutes,
  input  logic [3:0] msd_seconds,
  input  logic [3:0] lsd_seconds,
  output logic       sdata,
  output logic       sclk,
  output logic       latch,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Last divider count of each half shift-clock period.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // Segment byte {dp,g,f,e,d,c,b,a}, active-high; non-BCD values show a dash.
  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h40;
    endcase
    return s;
  endfunction

  // Tens-of-minutes digit: optionally blank when zero.
  function automatic logic [7:0] seg_msd_min(input logic [3:0] v);
`ifdef BLANK_LEADING_ZERO_EN
    return (v == 4'd0) ? 8'h00 : seg7(v);
`else
    return seg7(v);
`endif
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  div_q, div_d;
  logic [31:0] frame_q, frame_d;
  logic        sdata_q, sdata_d;
  logic        sclk_q, sclk_d;
  logic        latch_q, latch_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] capture;
  logic [4:0]  bit_idx_dec;
  logic        div_last;

  // The dp bit of the units-of-minutes byte is the minutes.seconds separator.
  assign capture = {seg_msd_min(msd_minutes), seg7(lsd_minutes) | 8'h80,
                    seg7(msd_seconds), seg7(lsd_seconds)};
  assign bit_idx_dec = bit_idx_q - 5'd1;
  assign div_last    = (div_q == DIV_LAST);

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    div_d     = div_q;
    frame_d   = frame_q;
    sdata_d   = sdata_q;
    sclk_d    = sclk_q;
    latch_d   = latch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d   = capture;
          bit_idx_d = 5'd31;
          div_d     = 8'd0;
          sdata_d   = capture[31];
          sclk_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_d   = 8'd0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_d  = 8'd0;
          sclk_d = 1'b0;
          if (bit_idx_q == 5'd0) begin
            sdata_d = 1'b0;
            latch_d = 1'b1;
            state_d = LATCH;
          end else begin
            bit_idx_d = bit_idx_dec;
            sdata_d   = frame_q[bit_idx_dec];
            state_d   = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      LATCH: begin
        if (div_last) begin
          div_d   = 8'd0;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sdata_d = 1'b0;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a latch pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_idx_q <= 5'd0;
      div_q     <= 8'd0;
      frame_q   <= 32'd0;
      sdata_q   <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      div_q     <= div_d;
      frame_q   <= frame_d;
      sdata_q   <= sdata_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sdata = sdata_q;
  assign sclk  = sclk_q;
  assign latch = latch_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_display_shifter.sv
// Self-checking bench for bcd_display_shifter at CLK_DIV=2.
module tb_bcd_display_shifter;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] msd_minutes, lsd_minutes, msd_seconds, lsd_seconds;
  logic       sdata, sclk, latch, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_display_shifter #(.CLK_DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .msd_minutes(msd_minutes),
    .lsd_minutes(lsd_minutes),
    .msd_seconds(msd_seconds),
    .lsd_seconds(lsd_seconds),
    .sdata      (sdata),
    .sclk       (sclk),
    .latch      (latch),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start with the given digits and observes one frame for 140 cycles.
  // mode 1: set all digits to 9 after the 10th sclk rise
  // mode 2: pulse start again after the 10th sclk rise
  // mode 3: assert reset after the 16th sclk rise and stop observing
  task automatic run_frame(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d,
                           input int mode,
                           output logic [31:0] cap, output int edges,
                           output int busy_n, output int latch_n,
                           output int latch_p, output int done_n,
                           output int done_at, output logic [3:0] rst_obs);
    logic prev_sclk, prev_latch;
    cap = 32'd0; edges = 0; busy_n = 0; latch_n = 0; latch_p = 0;
    done_n = 0; done_at = -1; rst_obs = 4'hF;
    msd_minutes = a; lsd_minutes = b; msd_seconds = c; lsd_seconds = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev_sclk = 1'b0; prev_latch = 1'b0;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      start = 1'b0;
      if (busy) busy_n++;
      if (latch) latch_n++;
      if (latch && !prev_latch) latch_p++;
      if (done) begin done_n++; done_at = cyc; end
      if (sclk && !prev_sclk) begin
        cap = {cap[30:0], sdata};
        edges++;
        if (edges == 10 && mode == 1) begin
          msd_minutes = 4'd9; lsd_minutes = 4'd9;
          msd_seconds = 4'd9; lsd_seconds = 4'd9;
        end
        if (edges == 10 && mode == 2) start = 1'b1;
        if (edges == 16 && mode == 3) begin
          reset = 1'b1;
          #1;
          rst_obs = {sclk, busy, latch, done};
          break;
        end
      end
      prev_sclk = sclk; prev_latch = latch;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    msd_minutes = 4'd0; lsd_minutes = 4'd0; msd_seconds = 4'd0; lsd_seconds = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({sdata, sclk, latch, busy, done} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {sdata, sclk, latch, busy, done});
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({sdata, sclk, latch, busy, done} !== 5'b0)
      $display("FAIL reset_release: got %b want 00000", {sdata, sclk, latch, busy, done});
    else n_pass++;
  endtask

  task automatic test_idle();
    int bad = 0;
    int rises = 0;
    logic prev = 1'b0;
    start = 1'b0;
    msd_minutes = 4'd1; lsd_minutes = 4'd2; msd_seconds = 4'd3; lsd_seconds = 4'd4;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if ({sdata, sclk, latch, busy, done} !== 5'b0) bad++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    n_checks++; if (bad !== 0)
      $display("FAIL idle_outputs: got %0d nonzero cycles want 0", bad);
    else n_pass++;
    n_checks++; if (rises !== 0)
      $display("FAIL idle_sclk: got %0d edges want 0", rises);
    else n_pass++;
  endtask

  task automatic test_frame_1234();
    logic [31:0] cap; int e, bn, ln, lp, dn, da; logic [3:0] ro;
    run_frame(4'd1, 4'd2, 4'd3, 4'd4, 0, cap, e, bn, ln, lp, dn, da, ro);
    n_checks++; if (cap !== 32'h06DB4F66)
      $display("FAIL f1234_frame: got %h want 06db4f66", cap); else n_pass++;
    n_checks++; if (e !== 32)
      $display("FAIL f1234_edges: got %0d want 32", e); else n_pass++;
    n_checks++; if (bn !== 130)
      $display("FAIL f1234_busy: got %0d want 130", bn); else n_pass++;
    n_checks++; if (ln !== 2 || lp !== 1)
      $display("FAIL f1234_latch: got %0d cycles %0d pulses want 2 1", ln, lp); else n_pass++;
    n_checks++; if (dn !== 1 || da !== 131)
      $display("FAIL f1234_done: got %0d pulses at %0d want 1 at 131", dn, da); else n_pass++;
  endtask

  task automatic test_frame_0559();
    logic [31:0] cap, want; int e, bn, ln, lp, dn, da; logic [3:0] ro;
`ifdef BLANK_LEADING_ZERO_EN
    want = 32'h00ED6D6F;
`else
    want = 32'h3FED6D6F;
`endif
    run_frame(4'd0, 4'd5, 4'd5, 4'd9, 0, cap, e, bn, ln, lp, dn, da, ro);
    n_checks++; if (cap !== want)
      $display("FAIL f0559_frame: got %h want %h", cap, want); else n_pass++;
    n_checks++; if (bn !== 130)
      $display("FAIL f0559_busy: got %0d want 130", bn); else n_pass++;
  endtask

  task automatic test_capture_hold();
    logic [31:0] cap; int e, bn, ln, lp, dn, da; logic [3:0] ro;
    run_frame(4'hA, 4'hF, 4'd0, 4'd0, 1, cap, e, bn, ln, lp, dn, da, ro);
    n_checks++; if (cap !== 32'h40C03F3F)
      $display("FAIL hold_frame: got %h want 40c03f3f", cap); else n_pass++;
    n_checks++; if (e !== 32)
      $display("FAIL hold_edges: got %0d want 32", e); else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [31:0] cap; int e, bn, ln, lp, dn, da; logic [3:0] ro;
    run_frame(4'd8, 4'd7, 4'd6, 4'd1, 2, cap, e, bn, ln, lp, dn, da, ro);
    n_checks++; if (cap !== 32'h7F877D06)
      $display("FAIL ign_frame: got %h want 7f877d06", cap); else n_pass++;
    n_checks++; if (lp !== 1 || e !== 32)
      $display("FAIL ign_latch: got %0d pulses %0d edges want 1 32", lp, e); else n_pass++;
    n_checks++; if (bn !== 130 || dn !== 1)
      $display("FAIL ign_busy: got busy %0d done %0d want 130 1", bn, dn); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] cap; int e, bn, ln, lp, dn, da; logic [3:0] ro;
    int lat = 0;
    int dns = 0;
    run_frame(4'd1, 4'd2, 4'd3, 4'd4, 3, cap, e, bn, ln, lp, dn, da, ro);
    n_checks++; if (ro !== 4'b0000)
      $display("FAIL rstmid_outputs: got sclk,busy,latch,done=%b want 0000", ro); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (latch) lat++;
      if (done) dns++;
      @(posedge clk); #1;
    end
    n_checks++; if (lat !== 0 || dns !== 0)
      $display("FAIL rstmid_no_pulse: got latch %0d done %0d want 0 0", lat, dns); else n_pass++;
    run_frame(4'd1, 4'd2, 4'd3, 4'd4, 0, cap, e, bn, ln, lp, dn, da, ro);
    n_checks++; if (cap !== 32'h06DB4F66 || e !== 32 || dn !== 1)
      $display("FAIL rstmid_next: got %h edges %0d done %0d want 06db4f66 32 1", cap, e, dn); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dns = 0;
    msd_minutes = 4'd2; lsd_minutes = 4'd3; msd_seconds = 4'd5; lsd_seconds = 4'd9;
    start = 1'b1;
    for (int i = 0; i < 270; i++) begin
      @(posedge clk); #1;
      if (done) dns++;
    end
    start = 1'b0;
    n_checks++; if (dns !== 2)
      $display("FAIL b2b_done: got %0d pulses want 2", dns); else n_pass++;
    repeat (300) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || sclk !== 1'b0)
      $display("FAIL b2b_idle: got busy %b sclk %b want 0 0", busy, sclk); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame_1234();
    test_frame_0559();
    test_capture_hold();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
